adder8_44: RTL and testbench

8-bit binary adder with carry-in and carry-out, built from two 4-bit carry-lookahead groups (low nibble, high nibble) chained by a group carry. The sum and carry-out are registered, so the block is a single-stage pipelined arithmetic primitive. It is used wherever a datapath needs a clocked 8-bit add with carry chaining, for example cascading into wider adders through Cout.

---
 rtl/adder8_44.sv | 64 ++++++
 tb/tb_adder8_44.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/adder8_44.sv
// Registered 8-bit adder with carry-in/out, built from two 4-bit
// carry-lookahead groups chained by the low group's carry.
module adder8_44 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] sum,
    output logic       Cout
);

    localparam int unsigned W  = 8;
    localparam int unsigned GW = 4;

    // 4-bit lookahead: returns {P, G, c3, c2, c1} for the group's carry-in ci
    function automatic logic [GW:0] cla4(input logic [GW-1:0] g,
                                         input logic [GW-1:0] p,
                                         input logic          ci);
        logic c1, c2, c3, gg, pg;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        pg = &p;
        return {pg, gg, c3, c2, c1};
    endfunction

    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W:0]    c;
    logic [GW:0]   lo;
    logic [GW:0]   hi;
    logic [W-1:0]  sum_next;
    logic          cout_next;

    always_comb begin
        g         = A & B;
        p         = A ^ B;
        c         = '0;
        c[0]      = Cin;
        lo        = cla4(g[GW-1:0], p[GW-1:0], Cin);
        c[3:1]    = lo[2:0];
        c[4]      = lo[3] | (lo[4] & Cin);
        hi        = cla4(g[W-1:GW], p[W-1:GW], c[4]);
        c[7:5]    = hi[2:0];
        c[8]      = hi[3] | (hi[4] & c[4]);
        sum_next  = p ^ c[W-1:0];
        cout_next = c[W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum  <= '0;
            Cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            Cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_adder8_44.sv
// Self-checking bench for adder8_44: directed vectors with literal results
// plus randomized operands and reset pulses checked against an arithmetic model.
module tb_adder8_44;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] sum;
    logic       Cout;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp9 = 9'h000;

    adder8_44 dut (
        .clk  (clk),
        .reset(reset),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .sum  (sum),
        .Cout (Cout)
    );

    always #5 clk = ~clk;

    // Model: result of the operands seen at the last edge, zero while in reset
    always @(posedge clk or negedge reset) begin
        if (!reset) exp9 = 9'h000;
        else        exp9 = 9'(A) + 9'(B) + 9'(Cin);
    end

    always @(negedge clk) begin
        checks++;
        if ({Cout, sum} !== exp9) begin
            errors++;
            $display("FAIL model_cmp t=%0t got Cout=%b sum=%h want Cout=%b sum=%h",
                     $time, Cout, sum, exp9[8], exp9[7:0]);
        end
    end

    task automatic chk(input string name, input logic [8:0] want);
        checks++;
        if ({Cout, sum} !== want) begin
            errors++;
            $display("FAIL %s t=%0t got Cout=%b sum=%h want Cout=%b sum=%h",
                     name, $time, Cout, sum, want[8], want[7:0]);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        #1;
        A   = a;
        B   = b;
        Cin = ci;
    endtask

    task automatic vec(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [8:0] want);
        drive(a, b, ci);
        @(posedge clk);
        #1;
        chk(name, want);
    endtask

    initial begin
        reset = 1'b0;
        A     = 8'hFF;
        B     = 8'hFF;
        Cin   = 1'b1;
        #1;
        chk("reset_async", 9'h000);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 9'h000);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", 9'h1FF);

        vec("cin_a", 8'h51, 8'h1E, 1'b1, 9'h070);
        vec("cin_b", 8'h51, 8'h02, 1'b1, 9'h054);
        vec("cin_c", 8'h03, 8'h1E, 1'b1, 9'h022);
        vec("cout_a", 8'h59, 8'hDE, 1'b0, 9'h137);
        vec("cout_b", 8'h43, 8'hDE, 1'b0, 9'h121);
        vec("prop_0", 8'h79, 8'h86, 1'b0, 9'h0FF);
        vec("prop_1", 8'h79, 8'h86, 1'b1, 9'h100);

        // Inputs changing between edges must not disturb the held result
        #2;
        A = 8'h00;
        B = 8'h01;
        #1;
        chk("hold_between_edges", 9'h100);

        vec("b2b_0", 8'h50, 8'h46, 1'b0, 9'h096);
        vec("b2b_1", 8'h41, 8'h0E, 1'b0, 9'h04F);
        vec("b2b_2", 8'h5F, 8'h9E, 1'b0, 9'h0FD);
        vec("b2b_3", 8'h55, 8'h9E, 1'b0, 9'h0F3);
        vec("b2b_4", 8'h0F, 8'h9E, 1'b1, 9'h0AE);

        // Async reset mid-stream, then resume
        vec("mid_pre_0", 8'h50, 8'h46, 1'b0, 9'h096);
        vec("mid_pre_1", 8'h41, 8'h0E, 1'b0, 9'h04F);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_reset_drop", 9'h000);
        drive(8'h5F, 8'h9E, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_reset_held", 9'h000);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_resume_0", 9'h0FD);
        vec("mid_resume_1", 8'h55, 8'h9E, 1'b0, 9'h0F3);
        vec("mid_resume_2", 8'h0F, 8'h9E, 1'b1, 9'h0AE);

        // Randomized operands with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            A     = 8'($urandom);
            B     = 8'($urandom);
            Cin   = 1'($urandom);
            reset = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
